// File: rtl/frame_reader_axi_if.sv
// AXI4 read-address and read-data channels between the frame reader (master) and the DDR4 slave port.
interface frame_reader_axi_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int ID_W   = 4
);
   logic [ID_W-1:0]   arid;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arlock;
   logic [3:0]        arcache;
   logic [2:0]        arprot;
   logic [3:0]        arqos;
   logic              arvalid;
   logic              arready;
   logic [ID_W-1:0]   rid;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/frame_reader_axi.sv
// AXI4 read master streaming a frame buffer into a pixel stream through a credit-managed beat FIFO.
// Build macro FRAME_READER_RRESP_CHECK_EN enables the sticky read-response error flag err_o.
module frame_reader_axi #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 64,
   parameter int ID_W         = 4,
   parameter int BURST_LEN    = 16,
   parameter int FRAME_BURSTS = 7200,
   parameter int FIFO_DEPTH   = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   frame_reader_axi_if.master m_axi,
   output logic [DATA_W-1:0] pix_data_o,
   output logic              pix_valid_o,
   input  logic              pix_ready_i,
   output logic              pix_sof_o,
   output logic              pix_eof_o,
   output logic              busy_o,
   output logic              err_o
);
   localparam int BURST_BYTES = BURST_LEN * 8;
   localparam int ADDR_LSB    = $clog2(BURST_BYTES);
   localparam int FRAME_BEATS = FRAME_BURSTS * BURST_LEN;
   localparam int PTR_W       = $clog2(FIFO_DEPTH);
   localparam int CNT_W       = PTR_W + 1;
   localparam int IDX_W       = $clog2(FRAME_BURSTS + 1);
   localparam int BEAT_W      = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
   localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << ADDR_LSB) - ADDR_W'(1));

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state_q, state_d;
   logic              start;
   logic [ADDR_W-1:0] base_q, base_src, next_addr;
   logic [IDX_W-1:0]  burst_idx_q, idx_src;
   logic              arvalid_q;
   logic [ADDR_W-1:0] araddr_q;
   logic [7:0]        arlen_q;
   logic [2:0]        arsize_q;
   logic [1:0]        arburst_q;
   logic [3:0]        arcache_q;
   logic [CNT_W-1:0]  outstanding_q, fifo_cnt_q, fifo_cnt_d;
   logic [CNT_W+1:0]  committed;
   logic              credit_ok, raise, ar_hs, r_hs, pix_hs, rready_q;
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [BEAT_W-1:0] beat_cnt_q;
   logic              beat_sof, beat_eof;
   logic [DATA_W+1:0] fifo_mem [FIFO_DEPTH];
   logic [DATA_W+1:0] fifo_head;
   logic              unused_in;

   assign ar_hs  = arvalid_q && m_axi.arready;
   assign r_hs   = m_axi.rvalid && rready_q;
   assign pix_hs = pix_valid_o && pix_ready_i;

   // A burst still waiting in AR already owns its FIFO space, so it is counted before its handshake.
   assign committed = (CNT_W+2)'(fifo_cnt_q) + (CNT_W+2)'(outstanding_q)
                    + (arvalid_q ? (CNT_W+2)'(BURST_LEN) : '0);
   assign credit_ok = (committed + (CNT_W+2)'(BURST_LEN)) <= (CNT_W+2)'(FIFO_DEPTH);

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      case (state_q)
         IDLE: if (enable_i) begin
            state_d = RUN;
            start   = 1'b1;
         end
         RUN: if (ar_hs && burst_idx_q == IDX_W'(FRAME_BURSTS)) state_d = DRAIN;
         DRAIN: if (outstanding_q == '0) begin
            if (enable_i) begin
               state_d = RUN;
               start   = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign idx_src   = start ? '0 : burst_idx_q;
   assign base_src  = start ? (base_addr_i & ADDR_MASK) : base_q;
   assign next_addr = base_src + ADDR_W'(idx_src) * ADDR_W'(BURST_BYTES);
   assign raise     = (start || state_q == RUN) && (idx_src < IDX_W'(FRAME_BURSTS))
                    && (!arvalid_q || ar_hs) && credit_ok;

   assign fifo_cnt_d = fifo_cnt_q + (r_hs ? CNT_W'(1) : '0) - (pix_hs ? CNT_W'(1) : '0);
   assign beat_sof   = (beat_cnt_q == '0);
   assign beat_eof   = (beat_cnt_q == BEAT_W'(FRAME_BEATS - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         arvalid_q     <= 1'b0;
         araddr_q      <= '0;
         arlen_q       <= '0;
         arsize_q      <= '0;
         arburst_q     <= '0;
         arcache_q     <= '0;
         burst_idx_q   <= '0;
         outstanding_q <= '0;
         fifo_cnt_q    <= '0;
         rready_q      <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         beat_cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (start) burst_idx_q <= '0;
         if (raise) begin
            arvalid_q   <= 1'b1;
            araddr_q    <= next_addr;
            arlen_q     <= 8'(BURST_LEN - 1);
            arsize_q    <= 3'd3;
            arburst_q   <= 2'b01;
            arcache_q   <= 4'b0011;
            burst_idx_q <= idx_src + 1'b1;
         end else if (ar_hs) begin
            arvalid_q <= 1'b0;
         end
         outstanding_q <= outstanding_q + (ar_hs ? CNT_W'(BURST_LEN) : '0) - (r_hs ? CNT_W'(1) : '0);
         fifo_cnt_q    <= fifo_cnt_d;
         rready_q      <= (fifo_cnt_d != CNT_W'(FIFO_DEPTH));
         if (r_hs) begin
            wr_ptr_q   <= wr_ptr_q + 1'b1;
            beat_cnt_q <= beat_eof ? '0 : beat_cnt_q + 1'b1;
         end
         if (pix_hs) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Beat data path: frame base and FIFO storage carry no reset.
   always_ff @(posedge clk_i) begin
      if (start) base_q <= base_addr_i & ADDR_MASK;
      if (r_hs) fifo_mem[wr_ptr_q] <= {beat_eof, beat_sof, m_axi.rdata};
   end

   assign fifo_head   = fifo_mem[rd_ptr_q];
   assign pix_valid_o = (fifo_cnt_q != '0);
   assign pix_data_o  = fifo_head[DATA_W-1:0];
   assign pix_sof_o   = pix_valid_o && fifo_head[DATA_W];
   assign pix_eof_o   = pix_valid_o && fifo_head[DATA_W+1];
   assign busy_o      = (state_q != IDLE);

   assign m_axi.arid    = '0;
   assign m_axi.araddr  = araddr_q;
   assign m_axi.arlen   = arlen_q;
   assign m_axi.arsize  = arsize_q;
   assign m_axi.arburst = arburst_q;
   assign m_axi.arlock  = 1'b0;
   assign m_axi.arcache = arcache_q;
   assign m_axi.arprot  = '0;
   assign m_axi.arqos   = '0;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.rready  = rready_q;

`ifdef FRAME_READER_RRESP_CHECK_EN
   logic err_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) err_q <= 1'b0;
      else if (r_hs && m_axi.rresp != 2'b00) err_q <= 1'b1;
   end
   assign err_o     = err_q;
   assign unused_in = ^{m_axi.rid, m_axi.rlast};
`else
   assign err_o     = 1'b0;
   assign unused_in = ^{m_axi.rid, m_axi.rlast, m_axi.rresp};
`endif
endmodule
